// File: rtl/regfile_dbg_access.sv
// Debug-side register file initiator: one read or write per request.
// Ports: i_clk/i_rst; req channel (i_req_valid/o_req_ready/i_req_we/
// i_req_addr/i_req_wdata); rsp channel (o_rsp_valid/i_rsp_ready/
// o_rsp_rdata/o_rsp_err); o_busy; register file read port 1 and
// write port (o_rf_rd_addr1/i_rf_rd_data1, o_rf_wr_en/addr/data).
module regfile_dbg_access #(
    parameter int XW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_halted,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [4:0]    i_req_addr,
    input  logic [XW-1:0] i_req_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [XW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_busy,
    output logic [4:0]    o_rf_rd_addr1,
    input  logic [XW-1:0] i_rf_rd_data1,
    output logic          o_rf_wr_en,
    output logic [4:0]    o_rf_wr_addr,
    output logic [XW-1:0] o_rf_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        WR,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ready_q;
    logic [4:0]    addr_q;
    logic [XW-1:0] wdata_q;
    logic [XW-1:0] rdata_q;
    logic          err_q;
    logic          req_fire;

    // ready is a flop so it stays low while reset is held and
    // never depends combinationally on i_rsp_ready.
    assign req_fire = i_req_valid && ready_q;

    always_comb begin
        state_nxt   = state;
        o_rsp_valid = 1'b0;
        o_rf_wr_en  = 1'b0;
        o_busy      = 1'b1;
        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (req_fire) begin
                    if (!i_halted)
                        state_nxt = RESP;
                    else if (i_req_we)
                        state_nxt = WR;
                    else
                        state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RESP;
            WR: begin
                o_rf_wr_en = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (req_fire) begin
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
                rdata_q <= '0;
                err_q   <= !i_halted;
            end
            // Register file read data arrives one cycle after the address.
            if (state == RD_CAP)
                rdata_q <= i_rf_rd_data1;
        end
    end

    assign o_req_ready   = ready_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_err     = err_q;
    assign o_rf_rd_addr1 = addr_q;
    assign o_rf_wr_addr  = addr_q;
    assign o_rf_wr_data  = wdata_q;

endmodule

// File: doc/regfile_dbg_access.md
# regfile_dbg_access

Debug-side initiator for the CPU register file. Accepts single-register read/write requests from the debug module over a valid/ready request channel, drives the register file's read port 1 and write port while the core is halted, and returns a response over a valid/ready response channel. Sits between the debug module and the CPU's register file ports, muxed in ahead of the core datapath when `o_busy` is high.

## Interface

- `XW`, 32, register width in bits; must match the register file.

- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_halted`  in  1  core is halted; debug access permitted
- `i_req_valid`  in  1  request present
- `o_req_ready`  out  1  request accepted when high with `i_req_valid`
- `i_req_we`  in  1  1 = write, 0 = read
- `i_req_addr`  in  5  register index (0..31)
- `i_req_wdata`  in  XW  write data
- `o_rsp_valid`  out  1  response present
- `i_rsp_ready`  in  1  response consumed when high with `o_rsp_valid`
- `o_rsp_rdata`  out  XW  read data (0 for writes and errors)
- `o_rsp_err`  out  1  request rejected (core not halted)
- `o_busy`  out  1  high in any state except IDLE; core side must not use the register file ports while high
- `o_rf_rd_addr1`  out  5  to register file read address 1
- `i_rf_rd_data1`  in  XW  from register file read data 1; 1-cycle registered latency
- `o_rf_wr_en`  out  1  to register file write enable
- `o_rf_wr_addr`  out  5  to register file write address
- `o_rf_wr_data`  out  XW  to register file write data

## Operation

- States: IDLE, RD_ADDR, RD_CAP, WR, RESP.
- IDLE: `o_req_ready`=1. On handshake, latch `we`, `addr`, `wdata` into internal registers.
  - `i_halted`=0 at handshake -> RESP with `o_rsp_err`=1, `o_rsp_rdata`=0; no register file access.
  - read -> RD_ADDR; write -> WR.
- RD_ADDR: drive `o_rf_rd_addr1` = latched addr -> RD_CAP.
- RD_CAP: keep driving address; capture `i_rf_rd_data1` into response data register -> RESP.
- WR: `o_rf_wr_en`=1, `o_rf_wr_addr`/`o_rf_wr_data` = latched values, for exactly one cycle -> RESP. Writes to address 0 are still issued; the register file discards them and the response carries `o_rsp_err`=0.
- RESP: `o_rsp_valid`=1, data/err stable until `i_rsp_ready`; on handshake -> IDLE.
- `o_req_ready`=0 in every state except IDLE; one outstanding request max.
- `i_halted` is sampled only at request acceptance; dropping it mid-operation does not abort the access.
- `o_rf_rd_addr1`, `o_rf_wr_addr`, `o_rf_wr_data` always reflect the latched request registers; only `o_rf_wr_en` qualifies a write.

## Timing

- Reset (`i_rst` high at a rising edge): state IDLE; all latched registers 0. Outputs: `o_req_ready`=1 (in the cycle after reset deasserts), `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0, `o_busy`=0, `o_rf_wr_en`=0, `o_rf_rd_addr1`=0, `o_rf_wr_addr`=0, `o_rf_wr_data`=0.
- While `i_rst` is held high, `o_req_ready` is 0.
- Reset mid-operation: any in-flight request and pending response are dropped; a write pulse scheduled for the next cycle is not issued.
- Request accepted at edge T:
  - Read: RD_ADDR in cycle T+1, RD_CAP in T+2 (data captured at end of T+2), and `o_rsp_valid` high from T+3.
  - Write: `o_rf_wr_en` high in cycle T+1 only, and `o_rsp_valid` high from T+2.
  - Error: `o_rsp_valid` high from T+1.
- Response handshake at edge R: IDLE and `o_req_ready`=1 in R+1. A new request can be accepted at the end of R+1, giving no combinational ready path from `i_rsp_ready`.
- All outputs are registered or decoded from state only; no combinational paths from inputs to outputs.

## Test plan

- Reset: hold `i_rst` 3 cycles with `i_req_valid`=1 -> no handshake; after release every output matches the reset values; `o_req_ready`=1 one cycle after release.
- Halted write then read: write x5 = 0xDEADBEEF -> `o_rf_wr_en` pulses one cycle with addr 5 and that data, and `o_rsp_valid` appears at T+2 with err=0. Then read x5 -> `o_rsp_rdata`=0xDEADBEEF at T+3.
- x0 access: write x0 = 0x12345678, then read x0 -> write response err=0; read returns 0x00000000.
- Not halted: `i_halted`=0, read x3 -> `o_rsp_valid` at T+1, `o_rsp_err`=1, `o_rsp_rdata`=0; `o_rf_wr_en` never asserts; `o_busy` low again after the handshake.
- Response backpressure: read x7 (preloaded 0xA5A5A5A5) with `i_rsp_ready`=0 for 5 cycles -> `o_rsp_valid`/data stable; `o_req_ready`=0 throughout; IDLE one cycle after `i_rsp_ready`=1.
- Mid-op events: drop `i_halted` in the WR cycle -> write still completes, err=0. Assert `i_rst` during RD_CAP -> no response is ever produced, and IDLE/reset values are restored.
